id_issue_ctrl: RTL and testbench
================================

Name: id_issue_ctrl

Overview:
- Issue controller between the fetch stage and the ID stage.
- Holds a per-register scoreboard of in-flight write-backs and stalls any instruction with a RAW or WAW hazard, inserting NOPs into ID instead.
- Supports a drain request that quiesces the pipeline until every pending write-back has retired.
- ID has no bypass: a register written at edge N is only readable by an instruction registered into ID at edge N+1 or later.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall counter.
- NOP_WORD, 32'hF0000000, instruction word issued as a bubble (opcode 111100).

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  asynchronous active-low reset
- if_valid  input  1  fetch presents a valid instruction
- if_instruction  input  [0:31]  opcode[0:5], rD[6:10], rA[11:15], rB[16:20], PPPWW[21:25], func[28:31]
- if_ready  output  1  instruction accepted this cycle (combinational)
- id_instruction  output  [0:31]  registered instruction word to ID
- id_valid  output  1  id_instruction is a real issued instruction
- wb_en  input  1  write-back commit this cycle
- wb_rD  input  [0:4]  write-back destination register
- drain_req  input  1  level request to stop issuing and empty the pipeline
- drain_done  output  1  drained; pipeline quiescent
- pending  output  [0:31]  scoreboard, bit i = register i has an in-flight write
- stall_cnt  output  [0:STALL_CNT_W-1]  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst=0, async): id_instruction=NOP_WORD, id_valid=0, pending=0, stall_cnt=0, drain_done=0, state RUN.

Decode (combinational on if_instruction):
- Opcode 101010: uses rA. Uses rB unless func is 1011, 1101 or 1111 (immediate forms). Writes rD.
- Opcode 100000: no register sources; writes rD.
- Opcode 100001: no register sources; no register write.
- Any other opcode: no sources, no write.
- Register 0 never causes a hazard and is never marked pending.

Hazard and issue:
- hazard = (any used source pending) OR (writes rD, rD≠0, and pending[rD]).
- The check uses the pending vector as it stands at the start of the cycle; a same-cycle wb clear does not remove the hazard.
- if_ready = (state==RUN) AND NOT hazard.

FSM states:
- RUN:
  - if_valid & if_ready → id_instruction<=if_instruction, id_valid<=1, set pending[rD] if the instruction writes rD≠0.
  - if_valid & hazard → go to STALL, issue NOP (id_valid<=0), stall_cnt+1.
  - !if_valid → issue NOP, id_valid<=0.
  - drain_req → go to DRAIN; drain takes priority over issue in that cycle.
- STALL:
  - Issue NOP each cycle and increment stall_cnt.
  - Return to RUN the cycle the hazard clears; the held instruction is accepted that cycle.
  - drain_req → DRAIN.
  - if_valid dropping → RUN.
- DRAIN:
  - Issue NOP, if_ready=0.
  - Go to DONE when pending==0 (evaluated after this cycle's clear).
- DONE:
  - drain_done=1, if_ready=0, NOPs issued.
  - drain_req deasserted → RUN, drain_done<=0.

Scoreboard:
- wb_en & wb_rD≠0 clears pending[wb_rD].
- Set and clear of the same bit in one cycle: set wins. This only arises on a spurious wb.
- wb to a non-pending register is ignored.

Counter:
- stall_cnt saturates at all-ones; it does not wrap.
- Not incremented in DRAIN or DONE.

Optional Feature:
- Macro ISSUE_WB_BYPASS_EN.
- Defined: a source or destination whose pending bit is being cleared by wb_en/wb_rD in the same cycle is treated as not pending. if_ready rises one cycle earlier. The ID register file must then provide write-through.
- Undefined: the behaviour above (no bypass; clear is visible the following cycle).

Test Plan:
- Reset, then if_valid=1 with 0xA8611000 (r3=r1,r2) → if_ready=1; next edge id_instruction=0xA8611000, id_valid=1, pending[3]=1.
- 0xA8611000 followed by 0xA8830800 (r4 reads r3) → second held with if_ready=0 and NOP 0xF0000000 issued; stall_cnt increments each cycle. Pulse wb_en, wb_rD=3 → accepted the cycle after the clear. With ISSUE_WB_BYPASS_EN it is accepted in the wb cycle.
- Immediate form 0xA883080B (func 1011, rB=1 field is an immediate) with pending[1]=1 → no stall (rB ignored); rA=r3 is checked.
- drain_req=1 with pending={3,4} → NOPs issued, if_ready=0. wb r3, then wb r4 → drain_done=1 one edge after the last clear. drain_req=0 → RUN.
- Force stall_cnt to all-ones by a prolonged stall → stays 0xFFFF.
- Assert rst=0 mid-STALL with pending≠0 → immediately pending=0, id_valid=0, id_instruction=0xF0000000, stall_cnt=0.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: issue gate between fetch and ID. Keeps a per-register scoreboard of
//   in-flight write-backs, stalls RAW/WAW hazards by issuing NOP_WORD bubbles, and
//   supports a drain handshake that quiesces issue until every pending write retires.
// Latency: one cycle, fetch -> id_instruction/id_valid registered on the accepting edge.
// Backpressure: if_ready is combinational; low on hazard, while draining, or when drained.
// Optional: define ISSUE_WB_BYPASS_EN to let a same-cycle write-back clear the hazard
//   (the ID register file must then write through).
// Ports: clk/rst (async active-low); if_valid/if_instruction/if_ready fetch side;
//   id_instruction/id_valid to ID; wb_en/wb_rD write-back retire; drain_req/drain_done
//   drain handshake; pending scoreboard (bit i = register i); stall_cnt saturating count.
module id_issue_ctrl #(
  parameter int          STALL_CNT_W = 16,
  parameter logic [0:31] NOP_WORD    = 32'hF0000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [0:31]            if_instruction,
  output logic                   if_ready,
  output logic [0:31]            id_instruction,
  output logic                   id_valid,
  input  logic                   wb_en,
  input  logic [0:4]             wb_rD,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic [0:31]            pending,
  output logic [0:STALL_CNT_W-1] stall_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_DRAIN, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [0:31]            id_instr_q, id_instr_d;
  logic                   id_valid_q, id_valid_d;
  logic [0:31]            pending_q, pending_d;
  logic [0:STALL_CNT_W-1] stall_cnt_q, stall_cnt_d;
  logic                   drain_done_q, drain_done_d;

  // Instruction fields (bit 0 is the MSB).
  logic [0:5] opcode;
  logic [0:4] rd, ra, rb;
  logic [0:3] func;
  assign opcode = if_instruction[0:5];
  assign rd     = if_instruction[6:10];
  assign ra     = if_instruction[11:15];
  assign rb     = if_instruction[16:20];
  assign func   = if_instruction[28:31];

  logic        uses_ra, uses_rb, writes_rd;
  logic [0:31] wb_clr, set_vec, chk_pend;
  logic        hazard, issue_ok, accept, stall_hit, can_issue;

  always_comb begin
    uses_ra   = (opcode == 6'b101010);
    uses_rb   = uses_ra && !(func inside {4'b1011, 4'b1101, 4'b1111});
    writes_rd = ((opcode == 6'b101010) || (opcode == 6'b100000)) && (rd != 5'd0);

    wb_clr = '0;
    if (wb_en && (wb_rD != 5'd0)) wb_clr[wb_rD] = 1'b1;

`ifdef ISSUE_WB_BYPASS_EN
    // A register retiring this cycle is already readable through the write-through RF.
    chk_pend = pending_q & ~wb_clr;
`else
    // Without bypass the retiring value is only visible one edge later.
    chk_pend = pending_q;
`endif

    hazard = (uses_ra && (ra != 5'd0) && chk_pend[ra])
          || (uses_rb && (rb != 5'd0) && chk_pend[rb])
          || (writes_rd && chk_pend[rd]);
  end

  // Ready is only raised when the instruction would really be taken this edge, so the
  // held instruction is accepted out of STALL and a drain request blocks acceptance.
  assign can_issue = (state_q == ST_RUN) || (state_q == ST_STALL);
  assign issue_ok  = can_issue && !drain_req && !hazard;
  assign accept    = if_valid && issue_ok;
  assign stall_hit = can_issue && !drain_req && if_valid && hazard;
  assign if_ready  = issue_ok;

  always_comb begin
    set_vec = '0;
    if (accept && writes_rd) set_vec[rd] = 1'b1;
    // Set is applied after clear so a spurious wb to a newly issued rd loses.
    pending_d = (pending_q & ~wb_clr) | set_vec;
  end

  always_comb begin
    state_d      = state_q;
    id_instr_d   = NOP_WORD;
    id_valid_d   = 1'b0;
    stall_cnt_d  = stall_cnt_q;
    drain_done_d = drain_done_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (drain_req) begin
          state_d = ST_DRAIN;
        end else if (accept) begin
          state_d    = ST_RUN;
          id_instr_d = if_instruction;
          id_valid_d = 1'b1;
        end else if (stall_hit) begin
          state_d = ST_STALL;
          if (stall_cnt_q != {STALL_CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pending_d == '0) begin
          state_d      = ST_DONE;
          drain_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!drain_req) begin
          state_d      = ST_RUN;
          drain_done_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      id_instr_q   <= NOP_WORD;
      id_valid_q   <= 1'b0;
      pending_q    <= '0;
      stall_cnt_q  <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_instr_q   <= id_instr_d;
      id_valid_q   <= id_valid_d;
      pending_q    <= pending_d;
      stall_cnt_q  <= stall_cnt_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign id_instruction = id_instr_q;
  assign id_valid       = id_valid_q;
  assign pending        = pending_q;
  assign stall_cnt      = stall_cnt_q;
  assign drain_done     = drain_done_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: vector table, hand-written drain/saturation/reset sequences and a
//   randomized run against a scoreboard-level reference model of the issue controller.
// Ports of the DUT are all driven from initial-block tasks; outputs sampled 1ns after edges.
module tb_id_issue_ctrl;

  localparam int          CW  = 16;
  localparam logic [31:0] NOP = 32'hF0000000;
`ifdef ISSUE_WB_BYPASS_EN
  localparam int SC = 2;
`else
  localparam int SC = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [0:31]   if_instruction;
  logic          if_ready;
  logic [0:31]   id_instruction;
  logic          id_valid;
  logic          wb_en;
  logic [0:4]    wb_rD;
  logic          drain_req;
  logic          drain_done;
  logic [0:31]   pending;
  logic [0:CW-1] stall_cnt;

  always #5 clk = ~clk;

  id_issue_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instruction(if_instruction), .if_ready(if_ready),
    .id_instruction(id_instruction), .id_valid(id_valid),
    .wb_en(wb_en), .wb_rD(wb_rD),
    .drain_req(drain_req), .drain_done(drain_done),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  int   total = 0;
  int   bad   = 0;
  logic rdy_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard as a mask with bit r = register r.
  function automatic logic [31:0] pmask(input logic [0:31] p);
    logic [31:0] m;
    for (int r = 0; r < 32; r++) m[r] = p[r];
    return m;
  endfunction

  // Drive one cycle of inputs, sample if_ready mid-cycle, return 1ns after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic wb,
                      input logic [4:0] wr, input logic dr);
    if_valid       = v;
    if_instruction = ins;
    wb_en          = wb;
    wb_rD          = wr;
    drain_req      = dr;
    #2;
    rdy_s = if_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_valid = 1'b0; if_instruction = 32'h0; wb_en = 1'b0; wb_rD = 5'd0; drain_req = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic v; logic [31:0] ins; logic wb; logic [4:0] wr; logic dr;
    logic rdy; logic vld; logic [31:0] idi; logic [31:0] pm; logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic wb,
                              input logic [4:0] wr, input logic rdy, input logic vld,
                              input logic [31:0] idi, input logic [31:0] pm, input int cnt);
    vec_t t;
    t.v = v; t.ins = ins; t.wb = wb; t.wr = wr; t.dr = 1'b0;
    t.rdy = rdy; t.vld = vld; t.idi = idi; t.pm = pm; t.cnt = 16'(cnt);
    return t;
  endfunction

  vec_t tbl[17];

  // ---------------- reference model ----------------
  int          m_mode;   // 0 issuing, 1 draining, 2 drained
  logic [0:31] m_pend;
  int          m_cnt;
  logic        m_vld;
  logic [31:0] m_ins;
  logic        m_done;

  task automatic decode(input logic [31:0] w, output logic ua, output logic ub,
                        output logic wd, output int a, output int b, output int d);
    int op, fn;
    op = int'(w >> 26);
    fn = int'(w % 16);
    d  = int'((w >> 21) % 32);
    a  = int'((w >> 16) % 32);
    b  = int'((w >> 11) % 32);
    ua = (op == 42);
    ub = ua && !(fn == 11 || fn == 13 || fn == 15);
    wd = (op == 42) || (op == 32);
  endtask

  task automatic model(input logic v, input logic [31:0] ins, input logic wb,
                       input logic [4:0] wr, input logic dr, output logic rdy);
    logic [0:31] look;
    logic ua, ub, wd, haz;
    int a, b, d;
    decode(ins, ua, ub, wd, a, b, d);
    look = m_pend;
`ifdef ISSUE_WB_BYPASS_EN
    if (wb && wr != 0) look[wr] = 1'b0;
`endif
    haz = (ua && a != 0 && look[a]) || (ub && b != 0 && look[b]) || (wd && d != 0 && look[d]);
    rdy = (m_mode == 0) && !dr && !haz;
    if (wb && wr != 0) m_pend[wr] = 1'b0;
    m_vld = 1'b0;
    m_ins = NOP;
    case (m_mode)
      0: begin
        if (dr) m_mode = 1;
        else if (v && rdy) begin
          m_vld = 1'b1;
          m_ins = ins;
          if (wd && d != 0) m_pend[d] = 1'b1;
        end else if (v && m_cnt < 65535) m_cnt++;
      end
      1: if (m_pend == '0) begin m_mode = 2; m_done = 1'b1; end
      default: if (!dr) begin m_mode = 0; m_done = 1'b0; end
    endcase
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    logic [3:0]  fn;
    case ($urandom_range(0, 4))
      0: fn = 4'hB;
      1: fn = 4'hD;
      2: fn = 4'hF;
      3: fn = 4'h3;
      default: fn = 4'h0;
    endcase
    case ($urandom_range(0, 3))
      0: w = (32'd42 << 26) | (32'($urandom_range(0, 7)) << 21) | (32'($urandom_range(0, 7)) << 16)
             | (32'($urandom_range(0, 7)) << 11) | 32'(fn);
      1: w = (32'd32 << 26) | (32'($urandom_range(0, 7)) << 21);
      2: w = (32'd33 << 26) | (32'($urandom_range(0, 7)) << 21);
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    logic        rv, rwb, rdr, erdy;
    logic [31:0] rins;
    logic [4:0]  rwr;

    tbl[0]  = mk(1, 32'hA8611000, 0, 0, 1, 1, 32'hA8611000, 32'h08, 0);
    tbl[1]  = mk(1, 32'hA8830800, 0, 0, 0, 0, NOP,          32'h08, 1);
    tbl[2]  = mk(1, 32'hA8830800, 0, 0, 0, 0, NOP,          32'h08, 2);
`ifdef ISSUE_WB_BYPASS_EN
    tbl[3]  = mk(1, 32'hA8830800, 1, 3, 1, 1, 32'hA8830800, 32'h10, 2);
    tbl[4]  = mk(0, 32'h00000000, 0, 0, 1, 0, NOP,          32'h10, 2);
`else
    tbl[3]  = mk(1, 32'hA8830800, 1, 3, 0, 0, NOP,          32'h00, 3);
    tbl[4]  = mk(1, 32'hA8830800, 0, 0, 1, 1, 32'hA8830800, 32'h10, 3);
`endif
    tbl[5]  = mk(1, 32'h80200000, 0, 0, 1, 1, 32'h80200000, 32'h12, SC);
    tbl[6]  = mk(1, 32'hA8A3080B, 0, 0, 1, 1, 32'hA8A3080B, 32'h32, SC);
    tbl[7]  = mk(1, 32'hA8C30800, 0, 0, 0, 0, NOP,          32'h32, SC + 1);
    tbl[8]  = mk(0, 32'h00000000, 0, 0, 1, 0, NOP,          32'h32, SC + 1);
    tbl[9]  = mk(1, 32'h80800000, 0, 0, 0, 0, NOP,          32'h32, SC + 2);
    tbl[10] = mk(1, 32'h80000000, 0, 0, 1, 1, 32'h80000000, 32'h32, SC + 2);
    tbl[11] = mk(1, 32'h84A00000, 0, 0, 1, 1, 32'h84A00000, 32'h32, SC + 2);
    tbl[12] = mk(0, 32'h00000000, 1, 7, 1, 0, NOP,          32'h32, SC + 2);
    tbl[13] = mk(0, 32'h00000000, 1, 0, 1, 0, NOP,          32'h32, SC + 2);
    tbl[14] = mk(0, 32'h00000000, 1, 1, 1, 0, NOP,          32'h30, SC + 2);
    tbl[15] = mk(0, 32'h00000000, 1, 4, 1, 0, NOP,          32'h20, SC + 2);
    tbl[16] = mk(0, 32'h00000000, 1, 5, 1, 0, NOP,          32'h00, SC + 2);

    do_reset();
    chk("reset id_instruction", id_instruction, NOP);
    chk("reset id_valid", 32'(id_valid), 0);
    chk("reset pending", pmask(pending), 0);
    chk("reset stall_cnt", 32'(stall_cnt), 0);
    chk("reset drain_done", 32'(drain_done), 0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].ins, tbl[i].wb, tbl[i].wr, tbl[i].dr);
      chk($sformatf("row%0d if_ready", i), 32'(rdy_s), 32'(tbl[i].rdy));
      chk($sformatf("row%0d id_valid", i), 32'(id_valid), 32'(tbl[i].vld));
      chk($sformatf("row%0d id_instruction", i), id_instruction, tbl[i].idi);
      chk($sformatf("row%0d pending", i), pmask(pending), tbl[i].pm);
      chk($sformatf("row%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
      chk($sformatf("row%0d drain_done", i), 32'(drain_done), 0);
    end

    // Drain with r3 and r4 outstanding.
    step(1, 32'hA8611000, 0, 0, 0);
    step(1, 32'h80800000, 0, 0, 0);
    chk("drain setup pending", pmask(pending), 32'h18);
    step(1, 32'h80A00000, 0, 0, 1);
    chk("drain req if_ready", 32'(rdy_s), 0);
    chk("drain req id_valid", 32'(id_valid), 0);
    chk("drain req id_instruction", id_instruction, NOP);
    chk("drain req pending", pmask(pending), 32'h18);
    step(0, 32'h0, 1, 3, 1);
    chk("drain wb3 if_ready", 32'(rdy_s), 0);
    chk("drain wb3 pending", pmask(pending), 32'h10);
    chk("drain wb3 drain_done", 32'(drain_done), 0);
    step(0, 32'h0, 1, 4, 1);
    chk("drain wb4 pending", pmask(pending), 0);
    chk("drain wb4 drain_done", 32'(drain_done), 1);
    step(1, 32'h80A00000, 0, 0, 1);
    chk("drained if_ready", 32'(rdy_s), 0);
    chk("drained drain_done", 32'(drain_done), 1);
    chk("drained id_valid", 32'(id_valid), 0);
    step(1, 32'h80A00000, 0, 0, 0);
    chk("undrain if_ready", 32'(rdy_s), 0);
    chk("undrain drain_done", 32'(drain_done), 0);
    step(1, 32'h80A00000, 0, 0, 0);
    chk("resume if_ready", 32'(rdy_s), 1);
    chk("resume id_valid", 32'(id_valid), 1);
    chk("resume pending", pmask(pending), 32'h20);
    chk("resume stall_cnt", 32'(stall_cnt), 32'(SC + 2));

    // Randomized run against the model.
    do_reset();
    m_mode = 0; m_pend = '0; m_cnt = 0; m_vld = 1'b0; m_ins = NOP; m_done = 1'b0;
    rdr = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      rv   = ($urandom_range(0, 3) != 0);
      rins = rand_ins();
      rwb  = ($urandom_range(0, 2) == 0);
      rwr  = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) rdr = ~rdr;
      model(rv, rins, rwb, rwr, rdr, erdy);
      step(rv, rins, rwb, rwr, rdr);
      chk($sformatf("rand%0d if_ready", c), 32'(rdy_s), 32'(erdy));
      chk($sformatf("rand%0d id_valid", c), 32'(id_valid), 32'(m_vld));
      chk($sformatf("rand%0d id_instruction", c), id_instruction, m_ins);
      chk($sformatf("rand%0d pending", c), pmask(pending), pmask(m_pend));
      chk($sformatf("rand%0d stall_cnt", c), 32'(stall_cnt), 32'(m_cnt));
      chk($sformatf("rand%0d drain_done", c), 32'(drain_done), 32'(m_done));
    end

    // Prolonged stall to saturate the counter.
    do_reset();
    step(1, 32'hA8611000, 0, 0, 0);
    if_instruction = 32'hA8830800;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
    chk("sat id_valid", 32'(id_valid), 0);
    step(1, 32'hA8830800, 0, 0, 0);
    chk("sat hold if_ready", 32'(rdy_s), 0);
    chk("sat hold stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
    chk("sat hold pending", pmask(pending), 32'h08);

    // Asynchronous reset in the middle of the stall.
    #3;
    rst = 1'b0;
    #1;
    chk("async rst pending", pmask(pending), 0);
    chk("async rst id_valid", 32'(id_valid), 0);
    chk("async rst id_instruction", id_instruction, NOP);
    chk("async rst stall_cnt", 32'(stall_cnt), 0);
    chk("async rst drain_done", 32'(drain_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
